// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Brief    : Iterative multiply/divide unit with architectural HI/LO
//            registers. MULT/MULTU use radix-2 shift-add and DIV/DIVU use
//            restoring division, one bit per cycle. The pipeline stalls on
//            busy. MTHI/MTLO writes are accepted only while idle.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Iteration counter width; a WIDTH-cycle CALC phase counts 0..WIDTH-1
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]        LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]     ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0]   ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

   // FSM encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;

   // Operation context captured when start is accepted
   logic               is_div;      // op[1]: divide vs multiply
   logic               sign_a;      // dividend/multiplicand negative (signed ops only)
   logic               sign_b;      // divisor/multiplier negative (signed ops only)
   logic [WIDTH-1:0]   mag_a;       // |A|, multiplicand for the shift-add
   logic [WIDTH-1:0]   mag_b;       // |B|, divisor for the restoring divide
   logic [WIDTH-1:0]   a_orig;      // raw A, returned in HI on divide-by-zero

   // Iteration registers
   logic [2*WIDTH-1:0] prod;        // {partial product, remaining multiplier bits}
   logic [WIDTH-1:0]   quot;        // dividend bits shifting out / quotient bits shifting in
   logic [WIDTH-1:0]   rem;         // partial remainder (always < |B| between steps)

   // Combinational helpers
   logic               accept;
   logic               in_neg_a;
   logic               in_neg_b;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_fits;
   logic               res_neg;
   logic               b_is_zero;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quot_fixed;
   logic [WIDTH-1:0]   rem_fixed;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign accept = (state == S_IDLE) && start;
   assign busy   = (state != S_IDLE);

   // Operand conditioning, one iteration step of each algorithm, and sign fix-up
   always_comb begin
      // Signs only matter for signed ops (op[0]); unsigned ops pass through
      in_neg_a  = op[0] & A[WIDTH-1];
      in_neg_b  = op[0] & B[WIDTH-1];
      // Two's-complement magnitude; 0x80..0 maps to 2^(WIDTH-1) as unsigned
      in_mag_a  = in_neg_a ? (~A + ONE_W) : A;
      in_mag_b  = in_neg_b ? (~B + ONE_W) : B;

      // Shift-add: conditionally add |A| into the upper half, carry kept
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                  (prod[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

      // Restoring divide: bring down the next dividend bit and trial-subtract.
      // The shifted remainder is at most 2|B|-1, so the top bit of the
      // difference is exactly the borrow.
      div_shift = {rem, quot[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      div_fits  = ~div_diff[WIDTH];

      // Results are negative when the operand signs differ
      res_neg    = sign_a ^ sign_b;
      b_is_zero  = (mag_b == {WIDTH{1'b0}});
      prod_fixed = res_neg ? (~prod + ONE_2W) : prod;
      quot_fixed = res_neg ? (~quot + ONE_W) : quot;
      // Remainder follows the dividend's sign
      rem_fixed  = sign_a ? (~rem + ONE_W) : rem;

      res_hi = prod_fixed[2*WIDTH-1:WIDTH];
      res_lo = prod_fixed[WIDTH-1:0];
      if (is_div) begin
         if (b_is_zero) begin
            res_hi = a_orig;
            res_lo = {WIDTH{1'b1}};
         end else begin
            res_hi = rem_fixed;
            res_lo = quot_fixed;
         end
      end
   end

   // Sequencer: IDLE -> CALC (WIDTH iterations) -> FIX -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         count <= {CW{1'b0}};
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_CALC;
                  count <= {CW{1'b0}};
               end
            end
            S_CALC: begin
               if (count == LAST_ITER) begin
                  state <= S_FIX;
                  count <= {CW{1'b0}};
               end else begin
                  count <= count + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            S_FIX: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               count <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Operand capture on accept, then one multiply or divide step per CALC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= {WIDTH{1'b0}};
         mag_b  <= {WIDTH{1'b0}};
         a_orig <= {WIDTH{1'b0}};
         prod   <= {(2*WIDTH){1'b0}};
         quot   <= {WIDTH{1'b0}};
         rem    <= {WIDTH{1'b0}};
      end else if (accept) begin
         is_div <= op[1];
         sign_a <= in_neg_a;
         sign_b <= in_neg_b;
         mag_a  <= in_mag_a;
         mag_b  <= in_mag_b;
         a_orig <= A;
         // Multiplier sits in the low half; the accumulator (high half) is cleared
         prod   <= {{WIDTH{1'b0}}, in_mag_b};
         quot   <= in_mag_a;
         rem    <= {WIDTH{1'b0}};
      end else if (state == S_CALC) begin
         if (is_div) begin
            rem  <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], div_fits};
         end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
         end
      end
   end

   // HI/LO: results on leaving FIX; MTHI/MTLO only when idle and not starting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= {WIDTH{1'b0}};
         lo <= {WIDTH{1'b0}};
      end else if (state == S_FIX) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if ((state == S_IDLE) && !start) begin
         if (we_hi) begin
            hi <= wdata;
         end
         if (we_lo) begin
            lo <= wdata;
         end
      end
   end

   // Completion flags, registered so they pulse in the first IDLE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= (state == S_FIX);
         div_by_zero <= (state == S_FIX) && is_div && b_is_zero;
      end
   end

endmodule
`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the course CPU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle. Results land in HI/LO, which the datapath reads for MFHI/MFLO and writes for MTHI/MTLO.
- The pipeline uses busy to stall, so the single-cycle ALU's multiply/divide path comes off the critical path.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- A  in  WIDTH  multiplicand / dividend, captured when start accepted
- B  in  WIDTH  multiplier / divisor, captured when start accepted
- we_hi  in  1  MTHI write strobe
- we_lo  in  1  MTLO write strobe
- wdata  in  WIDTH  data for MTHI/MTLO
- busy  out  1  high while an operation is in progress (CALC or FIX)
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle
- div_by_zero  out  1  pulses with done when a divide had B==0
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
Reset:
- Async on rst_n low, from any state including mid-operation.
- State=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0.
- The in-flight operation is discarded.

FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE: busy=0. On start=1, latch op, |A|, |B| and the operand signs, clear the accumulator, counter=0, go to CALC.
  - For unsigned ops, |A|=A and |B|=B.
  - For signed ops, take the two's-complement magnitude. 0x80000000 maps to magnitude 2^31, so internal magnitude registers are WIDTH bits, unsigned.
- CALC: busy=1. Exactly WIDTH cycles, one iteration per cycle; counter counts 0..WIDTH-1, then go to FIX.
  - Multiply: radix-2 shift-add into a 2*WIDTH-bit product register.
  - Divide: restoring division with a WIDTH+1-bit partial remainder.
- FIX: busy=1, one cycle. Apply signs and write results:
  - MULT: negate the 64-bit product if signA^signB.
  - DIV: quotient negated if signA^signB; remainder negated if signA (remainder takes the dividend's sign).
  - On the FIX->IDLE edge, hi/lo take the results and done=1 for the following cycle, which is IDLE again.
  - A new start may be accepted in that same done cycle.

Latency:
- Start accepted at edge k; done=1 and hi/lo valid in the cycle after edge k+WIDTH+1 (33 cycles for WIDTH=32).
- busy is high for exactly WIDTH+1 cycles.

Boundary conditions:
- Divide by zero: skip no cycles (same latency). Result hi=A (original operand), lo=all ones; div_by_zero=1 together with done.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0; no error flag.
- start while busy: ignored, no queueing.
- we_hi/we_lo while busy: ignored.
- we_hi/we_lo in IDLE: registers update at that edge; both strobes may be set together.
- start together with we_hi/we_lo in IDLE: start wins, the write is dropped.
- A/B may change after acceptance without affecting the result.
- done and div_by_zero are registered outputs; busy decodes state (registered).

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse width 1, busy high 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULTU same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero pulses with done. Next op clears div_by_zero.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F in IDLE -> hi/lo update next edge. start+we_hi in same IDLE cycle -> hi unchanged until done. Second start during busy -> ignored, only one done.
- Assert rst_n=0 at CALC cycle 10 -> hi=lo=0, busy=0, no done. Start after release -> normal 33-cycle result.
